// File: rtl/noc_injection_arbiter.sv
// rtl/noc_injection_arbiter.sv - packet-granular round-robin arbiter for one NoC injection port
module noc_injection_arbiter #(
    parameter int NumInputs                = 4,
    parameter int NocDataWidth             = 64,
    parameter int flitTypeSize             = 2,
    parameter int NocVirtualChannelIdWidth = 3,
    parameter int NocBroadcastWidth        = 1
) (
    input  logic                                          m_axis_aclk,
    input  logic                                          m_axis_arstn,
    input  logic [NumInputs*NocDataWidth-1:0]             s_flit_i,
    input  logic [NumInputs*flitTypeSize-1:0]             s_flit_type_i,
    input  logic [NumInputs*NocVirtualChannelIdWidth-1:0] s_vc_i,
    input  logic [NumInputs*NocBroadcastWidth-1:0]        s_broadcast_i,
    input  logic [NumInputs-1:0]                          s_valid_i,
    output logic [NumInputs-1:0]                          s_ready_o,
    output logic [NocDataWidth-1:0]                       network_flit_o,
    output logic [flitTypeSize-1:0]                       network_flit_type_o,
    output logic [NocVirtualChannelIdWidth-1:0]           network_vc_o,
    output logic [NocBroadcastWidth-1:0]                  network_broadcast_o,
    output logic                                          network_valid_o,
    input  logic                                          network_ready_i,
    output logic [NumInputs-1:0]                          grant_o,
    output logic                                          protocol_err_o
);

    localparam int PtrW = (NumInputs > 1) ? $clog2(NumInputs) : 1;

    localparam logic [flitTypeSize-1:0] FlitHeader     = flitTypeSize'(0);
    localparam logic [flitTypeSize-1:0] FlitHeaderTail = flitTypeSize'(3);

    typedef enum logic {
        StIdle,
        StLocked
    } state_t;

    state_t                                state_q, state_d;
    logic [PtrW-1:0]                       ptr_q, ptr_d;
    logic [NumInputs-1:0]                  grant_q, grant_d;
    logic [NocDataWidth-1:0]               flit_q, flit_d;
    logic [flitTypeSize-1:0]               type_q, type_d;
    logic [NocVirtualChannelIdWidth-1:0]   vc_q, vc_d;
    logic [NocBroadcastWidth-1:0]          bc_q, bc_d;
    logic                                  valid_q, valid_d;
    logic                                  err_q, err_d;

    logic [NumInputs-1:0]                  eligible;
    logic [NumInputs-1:0]                  misplaced;
    logic [PtrW-1:0]                       scan_idx;
    logic [PtrW-1:0]                       win_idx;
    logic                                  win_found;
    logic [PtrW-1:0]                       grant_idx;
    logic [PtrW-1:0]                       sel_idx;
    logic [flitTypeSize-1:0]               sel_type;
    logic                                  sel_is_head;
    logic                                  slot_free;
    logic                                  xfer;

    function automatic logic is_head(input logic [flitTypeSize-1:0] t);
        return (t == FlitHeader) || (t == FlitHeaderTail);
    endfunction

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] idx);
        return (idx == PtrW'(NumInputs - 1)) ? '0 : idx + 1'b1;
    endfunction

    // Classify each source's current flit: header-type may start a packet, body/tail in IDLE is an error
    always_comb begin
        eligible  = '0;
        misplaced = '0;
        for (int i = 0; i < NumInputs; i++) begin
            if (is_head(s_flit_type_i[i*flitTypeSize +: flitTypeSize])) begin
                eligible[i] = s_valid_i[i];
            end else begin
                misplaced[i] = s_valid_i[i];
            end
        end
    end

    // Round-robin scan from the pointer upward with wrap; first eligible source wins
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < NumInputs; k++) begin
            scan_idx = PtrW'((int'(ptr_q) + k) % NumInputs);
            if (!win_found && eligible[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // Encode the held one-hot grant back to an index and pick the source feeding the output slot
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NumInputs; i++) begin
            if (grant_q[i]) begin
                grant_idx = PtrW'(i);
            end
        end
        sel_idx     = (state_q == StIdle) ? win_idx : grant_idx;
        sel_type    = s_flit_type_i[int'(sel_idx)*flitTypeSize +: flitTypeSize];
        sel_is_head = is_head(sel_type);
        slot_free   = !valid_q || network_ready_i;
    end

    // Output decode: ready at most one source; a locked source offering a new header is held off
    always_comb begin
        s_ready_o = '0;
        if (state_q == StIdle) begin
            if (win_found) begin
                s_ready_o[win_idx] = slot_free;
            end
        end else if (!sel_is_head) begin
            s_ready_o[grant_idx] = slot_free;
        end
        xfer = |(s_valid_i & s_ready_o);
    end

    // Next-state: lock on header, release on tail, advance the pointer past the finished packet
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        if (xfer) begin
            if (state_q == StIdle) begin
                grant_d = '0;
                grant_d[win_idx] = 1'b1;
                if (sel_type == FlitHeader) begin
                    state_d = StLocked;
                end else begin
                    ptr_d = next_ptr(win_idx);
                end
            end else if (sel_type == flitTypeSize'(2)) begin
                state_d = StIdle;
                ptr_d   = next_ptr(grant_idx);
            end
        end
    end

    // Output register load/drain and sticky protocol-error tracking
    always_comb begin
        flit_d  = flit_q;
        type_d  = type_q;
        vc_d    = vc_q;
        bc_d    = bc_q;
        valid_d = valid_q;
        if (xfer) begin
            flit_d  = s_flit_i[int'(sel_idx)*NocDataWidth +: NocDataWidth];
            type_d  = sel_type;
            vc_d    = s_vc_i[int'(sel_idx)*NocVirtualChannelIdWidth +: NocVirtualChannelIdWidth];
            bc_d    = s_broadcast_i[int'(sel_idx)*NocBroadcastWidth +: NocBroadcastWidth];
            valid_d = 1'b1;
        end else if (network_ready_i) begin
            valid_d = 1'b0;
        end
        err_d = err_q;
        if (state_q == StIdle) begin
            err_d = err_q | (|misplaced);
        end else if (s_valid_i[grant_idx] && sel_is_head) begin
            err_d = 1'b1;
        end
    end

    // State and datapath registers; reset drops any partial packet immediately
    always_ff @(posedge m_axis_aclk or negedge m_axis_arstn) begin
        if (!m_axis_arstn) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            grant_q <= '0;
            flit_q  <= '0;
            type_q  <= '0;
            vc_q    <= '0;
            bc_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            flit_q  <= flit_d;
            type_q  <= type_d;
            vc_q    <= vc_d;
            bc_q    <= bc_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign network_flit_o      = flit_q;
    assign network_flit_type_o = type_q;
    assign network_vc_o        = vc_q;
    assign network_broadcast_o = bc_q;
    assign network_valid_o     = valid_q;
    assign grant_o             = grant_q;
    assign protocol_err_o      = err_q;

endmodule
